// File: rtl/bcd_display.sv
// bcd_display: loads an unsigned word, converts it to four BCD digits with a
// serial double-dabble engine (one bit per clock), and drives four registered
// active-low seven-segment outputs {g,f,e,d,c,b,a}.
// Optional feature macro: BCD_DISPLAY_BLANK_LEADING_ZEROS_EN blanks leading zero digits.
module bcd_display #(
  parameter int unsigned WORD_W = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] value,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [6:0]        disp0,
  output logic [6:0]        disp1,
  output logic [6:0]        disp2,
  output logic [6:0]        disp3
);

  localparam int unsigned CNT_W = $clog2(WORD_W + 1);
  localparam int unsigned BCD_W = 20;
  localparam logic [6:0]  SEG_BLANK = 7'h7F;
  localparam logic [6:0]  SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

  state_t             state, state_d;
  logic [WORD_W-1:0]  sr, sr_d;
  logic [BCD_W-1:0]   bcd, bcd_d, bcd_adj;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               busy_d, done_d, overflow_d;
  logic [6:0]         disp0_d, disp1_d, disp2_d, disp3_d;

  // Digit to active-low segment pattern; non-decimal codes show blank.
  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Add 3 to every nibble that is 5 or more, ahead of the next shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

`ifdef BCD_DISPLAY_BLANK_LEADING_ZEROS_EN
  logic z3, z2, z1;
  assign z3 = (bcd[15:12] == 4'd0);
  assign z2 = (bcd[11:8]  == 4'd0);
  assign z1 = (bcd[7:4]   == 4'd0);
`endif

  // State register and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sr       <= '0;
      bcd      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      disp0    <= SEG_BLANK;
      disp1    <= SEG_BLANK;
      disp2    <= SEG_BLANK;
      disp3    <= SEG_BLANK;
    end else begin
      state    <= state_d;
      sr       <= sr_d;
      bcd      <= bcd_d;
      cnt      <= cnt_d;
      busy     <= busy_d;
      done     <= done_d;
      overflow <= overflow_d;
      disp0    <= disp0_d;
      disp1    <= disp1_d;
      disp2    <= disp2_d;
      disp3    <= disp3_d;
    end
  end

  // Next-state and next-register values; everything holds unless a state acts.
  always_comb begin
    state_d    = state;
    sr_d       = sr;
    bcd_d      = bcd;
    cnt_d      = cnt;
    busy_d     = busy;
    done_d     = 1'b0;
    overflow_d = overflow;
    disp0_d    = disp0;
    disp1_d    = disp1;
    disp2_d    = disp2;
    disp3_d    = disp3;
    case (state)
      IDLE: begin
        if (load) begin
          sr_d    = value;
          bcd_d   = '0;
          cnt_d   = CNT_W'(WORD_W);
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Top scratch bit can never be set for WORD_W <= 16, so truncation is safe.
        bcd_d = BCD_W'({bcd_adj, sr[WORD_W-1]});
        sr_d  = {sr[WORD_W-2:0], 1'b0};
        cnt_d = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_d = UPDATE;
      end
      UPDATE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
        if (bcd[19:16] != 4'd0) begin
          overflow_d = 1'b1;
          disp0_d    = SEG_DASH;
          disp1_d    = SEG_DASH;
          disp2_d    = SEG_DASH;
          disp3_d    = SEG_DASH;
        end else begin
          overflow_d = 1'b0;
          disp0_d    = seg(bcd[3:0]);
`ifdef BCD_DISPLAY_BLANK_LEADING_ZEROS_EN
          disp1_d    = (z3 && z2 && z1) ? SEG_BLANK : seg(bcd[7:4]);
          disp2_d    = (z3 && z2)       ? SEG_BLANK : seg(bcd[11:8]);
          disp3_d    = z3               ? SEG_BLANK : seg(bcd[15:12]);
`else
          disp1_d    = seg(bcd[7:4]);
          disp2_d    = seg(bcd[11:8]);
          disp3_d    = seg(bcd[15:12]);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bcd_display.sv
// Scoreboard bench for bcd_display: stimulus pushes the expected display word
// on each accepted load; per-instance monitors pop and compare on every done.
module tb_bcd_display;

  typedef struct packed {
    logic       ovf;
    logic [6:0] d3;
    logic [6:0] d2;
    logic [6:0] d1;
    logic [6:0] d0;
  } exp_t;

`ifdef BCD_DISPLAY_BLANK_LEADING_ZEROS_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif
  localparam logic [30:0] RST_VEC = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 3'b000};

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst10, load10, busy10, done10, ovf10;
  logic [9:0]  value10;
  logic [6:0]  a0, a1, a2, a3;
  logic        rst14, load14, busy14, done14, ovf14;
  logic [13:0] value14;
  logic [6:0]  b0, b1, b2, b3;

  bcd_display #(.WORD_W(10)) dut10 (
    .clock(clock), .reset(rst10), .load(load10), .value(value10),
    .busy(busy10), .done(done10), .overflow(ovf10),
    .disp0(a0), .disp1(a1), .disp2(a2), .disp3(a3)
  );

  bcd_display #(.WORD_W(14)) dut14 (
    .clock(clock), .reset(rst14), .load(load14), .value(value14),
    .busy(busy14), .done(done14), .overflow(ovf14),
    .disp0(b0), .disp1(b1), .disp2(b2), .disp3(b3)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t q10[$];
  exp_t q14[$];
  exp_t e10, e14;

  function automatic logic [30:0] v10();
    return {a3, a2, a1, a0, busy10, done10, ovf10};
  endfunction

  function automatic logic [30:0] v14();
    return {b3, b2, b1, b0, busy14, done14, ovf14};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  // Monitor for the 10-bit instance.
  always @(negedge clock) begin
    if (done10 === 1'b1) begin
      checks++;
      if (q10.size() == 0) begin
        errors++;
        $display("FAIL done10_unexpected got done=1 required no pulse");
      end else begin
        e10 = q10.pop_front();
        if ({ovf10, a3, a2, a1, a0} !== e10) begin
          errors++;
          $display("FAIL disp10 got %h required %h", {ovf10, a3, a2, a1, a0}, e10);
        end
      end
    end
  end

  // Monitor for the 14-bit instance.
  always @(negedge clock) begin
    if (done14 === 1'b1) begin
      checks++;
      if (q14.size() == 0) begin
        errors++;
        $display("FAIL done14_unexpected got done=1 required no pulse");
      end else begin
        e14 = q14.pop_front();
        if ({ovf14, b3, b2, b1, b0} !== e14) begin
          errors++;
          $display("FAIL disp14 got %h required %h", {ovf14, b3, b2, b1, b0}, e14);
        end
      end
    end
  end

  task automatic load_a(input logic [9:0] v, input exp_t e);
    @(negedge clock);
    load10 = 1'b1; value10 = v;
    q10.push_back(e);
    @(negedge clock);
    load10 = 1'b0; value10 = '0;
  endtask

  task automatic load_b(input logic [13:0] v, input exp_t e);
    @(negedge clock);
    load14 = 1'b1; value14 = v;
    q14.push_back(e);
    @(negedge clock);
    load14 = 1'b0; value14 = '0;
  endtask

  // Counts negedges with busy high (bounded); ends on the negedge where done should be high.
  task automatic busy_len(input int which, output int n);
    n = 0;
    while (((which == 10) ? busy10 : busy14) && n < 80) begin
      n++;
      @(negedge clock);
    end
  endtask

  int n;

  initial begin
    rst10 = 1'b1; rst14 = 1'b1;
    load10 = 1'b0; load14 = 1'b0;
    value10 = '0; value14 = '0;
    repeat (2) @(negedge clock);
    rst10 = 1'b0; rst14 = 1'b0;
    check("reset10", 64'(v10()), 64'(RST_VEC));
    check("reset14", 64'(v14()), 64'(RST_VEC));

    // Small value 5
    load_a(10'd5, {1'b0, LZ, LZ, LZ, 7'h12});
    busy_len(10, n);
    check("busy_len_5", 64'(n), 64'd11);
    check("done_after_5", 64'(done10), 64'd1);

    // Full scale 1023
    load_a(10'd1023, {1'b0, 7'h79, 7'h40, 7'h24, 7'h30});
    busy_len(10, n);
    check("busy_len_1023", 64'(n), 64'd11);
    check("done_after_1023", 64'(done10), 64'd1);

    // Zero
    load_a(10'd0, {1'b0, LZ, LZ, LZ, 7'h40});
    busy_len(10, n);
    check("busy_len_0", 64'(n), 64'd11);

    // Load 42, then a second load at E3 that must be ignored
    load_a(10'd42, {1'b0, LZ, LZ, 7'h19, 7'h24});
    @(negedge clock);
    @(negedge clock);
    load10 = 1'b1; value10 = 10'd7;
    @(negedge clock);
    load10 = 1'b0; value10 = '0;
    busy_len(10, n);
    check("busy_len_42_after_e3", 64'(n), 64'd8);

    // Asynchronous reset pulse mid-cycle while idle
    repeat (2) @(negedge clock);
    @(posedge clock);
    #2 rst10 = 1'b1;
    #1 check("reset10_async", 64'(v10()), 64'(RST_VEC));
    #1 rst10 = 1'b0;

    // Reset mid-conversion aborts without a done pulse
    load_a(10'd999, {1'b0, LZ, 7'h10, 7'h10, 7'h10});
    repeat (5) @(posedge clock);
    #1 rst10 = 1'b1;
    q10.delete();
    #1 check("reset10_midconv", 64'(v10()), 64'(RST_VEC));
    #1 rst10 = 1'b0;
    repeat (15) @(negedge clock);
    check("idle_after_abort", 64'(v10()), 64'(RST_VEC));

    // Load 8 after abort
    load_a(10'd8, {1'b0, LZ, LZ, LZ, 7'h00});
    busy_len(10, n);
    check("busy_len_8", 64'(n), 64'd11);

    // 14-bit instance: overflow and recovery
    load_b(14'd10000, {1'b1, 7'h3F, 7'h3F, 7'h3F, 7'h3F});
    busy_len(14, n);
    check("busy_len14_10000", 64'(n), 64'd15);
    check("done14_after_10000", 64'(done14), 64'd1);
    load_b(14'd9999, {1'b0, 7'h10, 7'h10, 7'h10, 7'h10});
    busy_len(14, n);
    check("busy_len14_9999", 64'(n), 64'd15);
    load_b(14'd16383, {1'b1, 7'h3F, 7'h3F, 7'h3F, 7'h3F});
    busy_len(14, n);
    load_b(14'd1000, {1'b0, 7'h79, 7'h40, 7'h40, 7'h40});
    busy_len(14, n);

    repeat (4) @(negedge clock);
    check("q10_drained", 64'(q10.size()), 64'd0);
    check("q14_drained", 64'(q14.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running required finished");
    $fatal(1);
  end

endmodule

// File: doc/bcd_display.md
# bcd_display

Sequential binary-to-seven-segment display driver that sits directly downstream of the CPU's output register. It accepts an unsigned result word on a one-cycle load strobe and converts it to four decimal digits with an iterative double-dabble (shift/add-3) engine, one bit per clock. It then drives four registered seven-segment outputs for the board's display digits.

## Interface

Parameters:
- WORD_W, default 10: width of the value to display; legal range 4..16.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  single-cycle strobe: capture value and start a conversion.
- value  input  WORD_W  unsigned binary number to display.
- busy  output  1  high while a conversion is in progress; load is ignored while high.
- done  output  1  one-cycle pulse: display outputs were updated on the preceding edge.
- overflow  output  1  latched high if the last converted value was greater than 9999.
- disp0  output  7  units digit, segments {g,f,e,d,c,b,a}, active-low.
- disp1  output  7  tens digit, same encoding.
- disp2  output  7  hundreds digit, same encoding.
- disp3  output  7  thousands digit, same encoding.

## Operation

- **Segment codes** (active-low): 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10, blank=0x7F, dash=0x3F.
- **Reset values:** disp0..disp3=0x7F, busy=0, done=0, overflow=0, FSM in IDLE.
- **FSM states:** IDLE, SHIFT, UPDATE.
- **IDLE:**
  - load=1 captures value into the shift register, clears the 20-bit BCD scratch (5 digits), sets the bit counter to WORD_W, and moves to SHIFT.
  - load=0 keeps the FSM in IDLE.
- **SHIFT:** each cycle, every BCD nibble ≥5 gets +3 added, then {scratch, shift register} shifts left by 1 and the counter decrements. When the counter reaches 1, move to UPDATE.
- **UPDATE:**
  - If scratch digit 4 is nonzero, overflow<=1 and all four displays are set to dash.
  - Otherwise overflow<=0 and digits 0..3 are encoded to disp0..disp3.
  - In both cases done<=1 and the FSM returns to IDLE.
- **Arithmetic:** unsigned only. The 5-digit scratch holds values up to 65535, so no intermediate overflow is possible for WORD_W≤16.
- **Load outside IDLE:** load asserted in SHIFT or UPDATE is ignored. It is not queued.
- **Value stability:** value only needs to be valid on the edge where load is sampled.
- **Output holding:** display outputs hold their last value between conversions. They change only on the UPDATE exit edge or on reset.
- **Reset mid-conversion:** reset during SHIFT or UPDATE aborts the conversion. All outputs return to their reset values immediately (asynchronously).

## Timing

- Load is accepted at edge E0.
- busy is registered: high from E0 through E(WORD_W+1), low after E(WORD_W+1).
- SHIFT occupies edges E1..E(WORD_W). UPDATE is the cycle ending at E(WORD_W+1).
- disp0..disp3 and overflow update at E(WORD_W+1). done is high for exactly the cycle following E(WORD_W+1).
- Latency from load to new display is WORD_W+1 clocks, which is 11 at the default width.
- Earliest next accepted load is E(WORD_W+2), i.e. a load coincident with done=1 is accepted.
- Maximum throughput is one conversion per WORD_W+2 clocks.

## Configuration

- Macro: BCD_DISPLAY_BLANK_LEADING_ZEROS_EN.
- **Defined:** at UPDATE, leading zero digits above the most significant nonzero digit are driven blank (0x7F). disp0 always shows a digit, so a value of 0 displays 0x40 on disp0 and blank on disp1..3. Dash/overflow display is unaffected.
- **Undefined:** all four digits are always displayed, including leading zeros.

## Test plan

- **Reset:** assert reset for 2 ns mid-cycle -> disp0..3=0x7F, busy=0, done=0, overflow=0 immediately, without waiting for a clock edge.
- **Small value:** load value=5 (WORD_W=10, macro undefined) -> done pulses in the cycle after E11; disp0=0x12, disp1..3=0x40. With the macro defined: disp1..3=0x7F.
- **Full-scale value:** load value=1023 -> disp3=0x79, disp2=0x40, disp1=0x24, disp0=0x30; overflow=0; busy high for exactly 11 cycles.
- **Load while busy:** load 42, then pulse load with value=7 at E3 -> the second load is ignored; display shows 42 (disp1=0x19, disp0=0x24); a single done pulse.
- **Reset mid-conversion:** load 999, assert reset at E5 -> outputs return to reset values, no done pulse. After release, load 8 -> disp0=0x00 after WORD_W+1 cycles.
- **Overflow:** with WORD_W=14, load 10000 -> overflow=1, all disp=0x3F. A following load of 9999 -> overflow=0, all disp=0x10.
